ball_motion_engine: RTL and testbench
=====================================

// Module: ball_motion_engine
// PURPOSE
//   Parametrised fixed-point ball position integrator for the pingpong motion path.
//   It runs one motion step per step_req: it adds signed-direction velocity to a sub-pixel position,
//   then reflects the ball off the top/bottom walls and detects left/right exits (score events).
//   It sits between the velocity/angle logic and the VGA renderer, which consumes pix_x/pix_y.
// PARAMETERS
//   X_W     11   integer bits of x position
//   Y_W     11   integer bits of y position
//   FRAC_W   4   fractional (sub-pixel) bits on both axes and on both velocities
//   V_W     11   velocity magnitude width, same Q format as position (integer+frac = V_W+FRAC_W)
//   X_MAX  799   right playfield edge (pixels); left edge is 0
//   Y_MAX  599   bottom playfield edge (pixels); top edge is 0
//   X_INIT 400   reset / serve x (pixels)
//   Y_INIT 300   reset / serve y (pixels)
// PORTS
//   clk          in   1              system clock
//   rst_n        in   1              reset: asynchronous, active-high (despite the name)
//   load_req     in   1              load pos from load_x/load_y (accepted only in IDLE)
//   load_x       in   X_W            load x, integer pixels (fraction cleared)
//   load_y       in   Y_W            load y, integer pixels (fraction cleared)
//   step_req     in   1              request one motion step (accepted only in IDLE)
//   vx_mag       in   V_W+FRAC_W     |vx|, Q(V_W).FRAC_W
//   vx_dir       in   1              0 = +x, 1 = -x
//   vy_mag       in   V_W+FRAC_W     |vy|, Q(V_W).FRAC_W
//   vy_dir       in   1              0 = +y (down), 1 = -y (up)
//   pix_x        out  X_W            integer part of x (to VGA)
//   pix_y        out  Y_W            integer part of y (to VGA)
//   dir_x_out    out  1              x direction after step (flips on exit)
//   dir_y_out    out  1              y direction after step (flips on bounce)
//   wall_hit     out  1              1-cycle pulse with done when top/bottom wall touched
//   score_left   out  1              1-cycle pulse with done: ball left through x<0
//   score_right  out  1              1-cycle pulse with done: ball left through x>X_MAX
//   busy         out  1              high from the cycle after acceptance until done
//   done         out  1              1-cycle pulse: outputs updated
// BEHAVIOUR
//   Reset is asynchronous and active-high. On reset: pos = (X_INIT, Y_INIT).0; dir_x_out = dir_y_out = 0;
//     busy, done, wall_hit, score_left and score_right are 0; state = IDLE.
//   States: IDLE -> ADD -> EDGE -> DONE -> IDLE.
//   IDLE: load_req has priority over step_req; a load takes 1 cycle and raises no done.
//     step_req latches vx/vy mag+dir and moves to ADD. Requests outside IDLE are ignored, not queued.
//   ADD: nx = x +/- vx_mag and ny = y +/- vy_mag, each computed 2 bits wider, signed.
//   EDGE, y axis: if ny < 0, ny = -ny, flip dir_y, set wall_hit.
//     If ny > Y_MAX, ny = 2*Y_MAX - ny, flip dir_y, set wall_hit.
//     Exactly on 0 or Y_MAX: no reflection; wall_hit is still set.
//     If vy_mag > Y_MAX the reflected result is clamped to [0, Y_MAX].
//   EDGE, x axis: if nx < 0, set score_left; if nx > X_MAX, set score_right.
//     On either exit: pos = (X_INIT, Y_INIT).0 and dir_x flips; the y result is discarded.
//     An exit on x overrides wall_hit (forced to 0).
//   DONE: registered pos/dir outputs update; done and flags pulse for exactly 1 cycle.
//     busy drops in the same cycle.
//   Latency: step_req sampled at edge N gives done high after edge N+3. Throughput is 1 step / 4 cycles.
//   Reset mid-step: returns to IDLE at once; no done pulse; reset position.
// CONFIGURATION
//   BALL_WALL_BOUNCE_EN defined: top/bottom reflection as above.
//   BALL_WALL_BOUNCE_EN undefined: y clamps to 0 / Y_MAX and dir_y is unchanged; wall_hit still pulses.
// TESTING  (X_W=Y_W=11, FRAC_W=4, defaults)
//   1 Reset, no requests -> pix=(400,300); busy=0; done=0; all flags 0.
//   2 step: vx=3.0 +x, vy=2.5 -y, from (400,300) -> done at N+3; pix=(403,297) (y=297.5); no flags.
//   3 load (100,1); step vy=3.0 -y -> EN: pix_y=2, dir_y_out=0, wall_hit=1;
//       not EN: pix_y=0, dir_y_out=1, wall_hit=1.
//   4 load (100,598); step vy=4.0 +y -> EN: pix_y=596, dir_y_out=1, wall_hit=1.
//   5 load (797,50); step vx=5.0 +x -> score_right=1; pix=(400,300); dir_x_out=1; wall_hit=0.
//   6 step then load_req/step_req during busy -> ignored, one done only;
//       rst_n high at ADD -> no done, pix=(400,300).

Source files
------------

// File: rtl/ball_motion_engine.sv
// Fixed-point ball position integrator: one add/reflect/exit step per step_req (IDLE->ADD->EDGE->DONE).
// Optional macro BALL_WALL_BOUNCE_EN: reflect off top/bottom walls instead of clamping.
module ball_motion_engine #(
   parameter int X_W    = 11,
   parameter int Y_W    = 11,
   parameter int FRAC_W = 4,
   parameter int V_W    = 11,
   parameter int X_MAX  = 799,
   parameter int Y_MAX  = 599,
   parameter int X_INIT = 400,
   parameter int Y_INIT = 300
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_req,
   input  logic [X_W-1:0]        load_x,
   input  logic [Y_W-1:0]        load_y,
   input  logic                  step_req,
   input  logic [V_W+FRAC_W-1:0] vx_mag,
   input  logic                  vx_dir,
   input  logic [V_W+FRAC_W-1:0] vy_mag,
   input  logic                  vy_dir,
   output logic [X_W-1:0]        pix_x,
   output logic [Y_W-1:0]        pix_y,
   output logic                  dir_x_out,
   output logic                  dir_y_out,
   output logic                  wall_hit,
   output logic                  score_left,
   output logic                  score_right,
   output logic                  busy,
   output logic                  done
);
   localparam int PXW = X_W + FRAC_W;
   localparam int PYW = Y_W + FRAC_W;
   localparam int VW  = V_W + FRAC_W;
   // Signed working widths: wide enough for pos +/- vel plus sign and doubling headroom
   localparam int SXW = ((X_W > V_W) ? X_W : V_W) + FRAC_W + 2;
   localparam int SYW = ((Y_W > V_W) ? Y_W : V_W) + FRAC_W + 2;

   localparam logic [PXW-1:0]        XINIT_F = PXW'(X_INIT * (1 << FRAC_W));
   localparam logic [PYW-1:0]        YINIT_F = PYW'(Y_INIT * (1 << FRAC_W));
   localparam logic signed [SXW-1:0] XMAX_F  = SXW'(X_MAX * (1 << FRAC_W));
   localparam logic signed [SYW-1:0] YMAX_F  = SYW'(Y_MAX * (1 << FRAC_W));
   localparam logic signed [SYW-1:0] YMAX2_F = SYW'(2 * Y_MAX * (1 << FRAC_W));

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_EDGE, S_DONE} state_t;

   state_t                  state_q;
   logic [PXW-1:0]          pos_x_q, res_x_q;
   logic [PYW-1:0]          pos_y_q, res_y_q;
   logic                    dir_x_q, dir_y_q, res_dx_q, res_dy_q;
   logic [VW-1:0]           vx_q, vy_q;
   logic                    vxd_q, vyd_q;
   logic signed [SXW-1:0]   nx_q;
   logic signed [SYW-1:0]   ny_q;
   logic                    res_wall_q, res_sl_q, res_sr_q;
   logic                    wall_q, sl_q, sr_q, busy_q, done_q;

   logic signed [SXW-1:0]   x_ext, vx_ext;
   logic signed [SYW-1:0]   y_ext, vy_ext, ry_d;
   logic                    flip_y_d, wall_d, exit_l_d, exit_r_d;

   assign x_ext  = $signed(SXW'(pos_x_q));
   assign vx_ext = $signed(SXW'(vx_q));
   assign y_ext  = $signed(SYW'(pos_y_q));
   assign vy_ext = $signed(SYW'(vy_q));

   always_comb begin
      ry_d     = ny_q;
      flip_y_d = 1'b0;
      wall_d   = ny_q[SYW-1] || (ny_q == '0) || (ny_q >= YMAX_F);
      exit_l_d = nx_q[SXW-1];
      exit_r_d = !nx_q[SXW-1] && (nx_q > XMAX_F);
`ifdef BALL_WALL_BOUNCE_EN
      if (ny_q[SYW-1]) begin
         ry_d     = -ny_q;
         flip_y_d = 1'b1;
         if (ry_d > YMAX_F) ry_d = YMAX_F;
      end else if (ny_q > YMAX_F) begin
         ry_d     = YMAX2_F - ny_q;
         flip_y_d = 1'b1;
         if (ry_d[SYW-1]) ry_d = '0;
      end
`else
      if (ny_q[SYW-1])         ry_d = '0;
      else if (ny_q > YMAX_F)  ry_d = YMAX_F;
`endif
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q    <= S_IDLE;
         pos_x_q    <= XINIT_F;
         pos_y_q    <= YINIT_F;
         dir_x_q    <= 1'b0;
         dir_y_q    <= 1'b0;
         vx_q       <= '0;
         vy_q       <= '0;
         vxd_q      <= 1'b0;
         vyd_q      <= 1'b0;
         nx_q       <= '0;
         ny_q       <= '0;
         res_x_q    <= '0;
         res_y_q    <= '0;
         res_dx_q   <= 1'b0;
         res_dy_q   <= 1'b0;
         res_wall_q <= 1'b0;
         res_sl_q   <= 1'b0;
         res_sr_q   <= 1'b0;
         wall_q     <= 1'b0;
         sl_q       <= 1'b0;
         sr_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         wall_q <= 1'b0;
         sl_q   <= 1'b0;
         sr_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (load_req) begin
                  pos_x_q <= {load_x, {FRAC_W{1'b0}}};
                  pos_y_q <= {load_y, {FRAC_W{1'b0}}};
               end else if (step_req) begin
                  vx_q    <= vx_mag;
                  vy_q    <= vy_mag;
                  vxd_q   <= vx_dir;
                  vyd_q   <= vy_dir;
                  busy_q  <= 1'b1;
                  state_q <= S_ADD;
               end
            end
            S_ADD: begin
               nx_q    <= vxd_q ? (x_ext - vx_ext) : (x_ext + vx_ext);
               ny_q    <= vyd_q ? (y_ext - vy_ext) : (y_ext + vy_ext);
               state_q <= S_EDGE;
            end
            S_EDGE: begin
               // An x exit re-serves the ball and throws away the whole y outcome
               if (exit_l_d || exit_r_d) begin
                  res_x_q    <= XINIT_F;
                  res_y_q    <= YINIT_F;
                  res_dx_q   <= ~vxd_q;
                  res_dy_q   <= vyd_q;
                  res_wall_q <= 1'b0;
               end else begin
                  res_x_q    <= nx_q[PXW-1:0];
                  res_y_q    <= ry_d[PYW-1:0];
                  res_dx_q   <= vxd_q;
                  res_dy_q   <= vyd_q ^ flip_y_d;
                  res_wall_q <= wall_d;
               end
               res_sl_q <= exit_l_d;
               res_sr_q <= exit_r_d;
               state_q  <= S_DONE;
            end
            S_DONE: begin
               pos_x_q <= res_x_q;
               pos_y_q <= res_y_q;
               dir_x_q <= res_dx_q;
               dir_y_q <= res_dy_q;
               wall_q  <= res_wall_q;
               sl_q    <= res_sl_q;
               sr_q    <= res_sr_q;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pix_x       = pos_x_q[PXW-1:FRAC_W];
   assign pix_y       = pos_y_q[PYW-1:FRAC_W];
   assign dir_x_out   = dir_x_q;
   assign dir_y_out   = dir_y_q;
   assign wall_hit    = wall_q;
   assign score_left  = sl_q;
   assign score_right = sr_q;
   assign busy        = busy_q;
   assign done        = done_q;
endmodule

// File: tb/tb_ball_motion_engine.sv
// Randomized self-checking bench for ball_motion_engine against a sixteenth-pixel integer model.
module tb_ball_motion_engine;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        load_req = 1'b0, step_req = 1'b0;
   logic [10:0] load_x = '0, load_y = '0;
   logic [14:0] vx_mag = '0, vy_mag = '0;
   logic        vx_dir = 1'b0, vy_dir = 1'b0;
   logic [10:0] pix_x, pix_y;
   logic        dir_x_out, dir_y_out, wall_hit, score_left, score_right, busy, done;

   int n_chk = 0, n_fail = 0;
   // model state, positions in 1/16 pixel
   int mx = 400*16, my = 300*16;
   logic mdx = 0, mdy = 0, mwall = 0, msl = 0, msr = 0;

   localparam int XM = 799*16, YM = 599*16;

   ball_motion_engine dut (
      .clk(clk), .rst_n(rst_n), .load_req(load_req), .load_x(load_x), .load_y(load_y),
      .step_req(step_req), .vx_mag(vx_mag), .vx_dir(vx_dir), .vy_mag(vy_mag), .vy_dir(vy_dir),
      .pix_x(pix_x), .pix_y(pix_y), .dir_x_out(dir_x_out), .dir_y_out(dir_y_out),
      .wall_hit(wall_hit), .score_left(score_left), .score_right(score_right),
      .busy(busy), .done(done));

   always #5 clk = ~clk;

   function automatic logic [26:0] obs();
      return {pix_x, pix_y, dir_x_out, dir_y_out, wall_hit, score_left, score_right};
   endfunction

   function automatic logic [26:0] expv();
      logic [10:0] ex, ey;
      ex = 11'(mx / 16);
      ey = 11'(my / 16);
      return {ex, ey, mdx, mdy, mwall, msl, msr};
   endfunction

   function automatic void model_step(input int vx, input logic vxd, input int vy, input logic vyd);
      int nx, ny;
      logic fy;
      nx = mx + (vxd ? -vx : vx);
      ny = my + (vyd ? -vy : vy);
      fy = 0;
      mwall = (ny <= 0) || (ny >= YM);
`ifdef BALL_WALL_BOUNCE_EN
      if (ny < 0) begin ny = -ny; fy = 1; if (ny > YM) ny = YM; end
      else if (ny > YM) begin ny = 2*YM - ny; fy = 1; if (ny < 0) ny = 0; end
`else
      if (ny < 0) ny = 0; else if (ny > YM) ny = YM;
`endif
      msl = nx < 0;
      msr = nx > XM;
      if (msl || msr) begin
         mx = 400*16; my = 300*16; mdx = ~vxd; mdy = vyd; mwall = 0;
      end else begin
         mx = nx; my = ny; mdx = vxd; mdy = vyd ^ fy;
      end
   endfunction

   task automatic do_load(input int lx, input int ly);
      @(negedge clk);
      load_req = 1; load_x = 11'(lx); load_y = 11'(ly);
      @(posedge clk);
      #1 load_req = 0;
      mx = lx*16; my = ly*16;
   endtask

   // Drives one step and records done/busy after edges N..N+3; leaves time just after N+3
   task automatic do_step(input int vx, input logic vxd, input int vy, input logic vyd,
                          output logic [3:0] dseq, output logic [3:0] bseq);
      @(negedge clk);
      step_req = 1; vx_mag = 15'(vx); vx_dir = vxd; vy_mag = 15'(vy); vy_dir = vyd;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1 step_req = 0;
         dseq[i] = done; bseq[i] = busy;
      end
      model_step(vx, vxd, vy, vyd);
   endtask

   task automatic test_reset();
      rst_n = 1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if (obs() !== {11'd400, 11'd300, 5'b0} || busy !== 0 || done !== 0) begin
         n_fail++;
         $display("FAIL reset: got %h busy=%b done=%b, want pix=(400,300) flags 0", obs(), busy, done);
      end
   endtask

   task automatic test_basic();
      logic [3:0] d, b;
      do_step(48, 0, 40, 1, d, b);
      n_chk++;
      if (d !== 4'b1000 || b !== 4'b0111) begin
         n_fail++; $display("FAIL basic_timing: done=%b busy=%b want 1000/0111", d, b);
      end
      n_chk++;
      if (pix_x !== 11'd403 || pix_y !== 11'd297 || obs() !== expv()) begin
         n_fail++; $display("FAIL basic_pos: got %h want %h (403,297)", obs(), expv());
      end
      @(posedge clk); #1;
      n_chk++;
      if (done !== 0) begin n_fail++; $display("FAIL basic_pulse: done=%b want 0", done); end
   endtask

   task automatic test_walls();
      logic [3:0] d, b;
      do_load(100, 1);
      do_step(0, 0, 48, 1, d, b);
      n_chk++;
`ifdef BALL_WALL_BOUNCE_EN
      if (pix_y !== 11'd2 || dir_y_out !== 0 || wall_hit !== 1 || obs() !== expv()) begin
`else
      if (pix_y !== 11'd0 || dir_y_out !== 1 || wall_hit !== 1 || obs() !== expv()) begin
`endif
         n_fail++; $display("FAIL top_wall: got %h want %h", obs(), expv());
      end
      do_load(100, 598);
      do_step(0, 0, 64, 0, d, b);
      n_chk++;
`ifdef BALL_WALL_BOUNCE_EN
      if (pix_y !== 11'd596 || dir_y_out !== 1 || wall_hit !== 1 || obs() !== expv()) begin
`else
      if (pix_y !== 11'd599 || dir_y_out !== 0 || wall_hit !== 1 || obs() !== expv()) begin
`endif
         n_fail++; $display("FAIL bottom_wall: got %h want %h", obs(), expv());
      end
      do_load(100, 0);
      do_step(16, 0, 0, 0, d, b);
      n_chk++;
      if (pix_y !== 11'd0 || wall_hit !== 1 || obs() !== expv()) begin
         n_fail++; $display("FAIL exact_top: got %h want %h", obs(), expv());
      end
   endtask

   task automatic test_score();
      logic [3:0] d, b;
      do_load(797, 50);
      do_step(80, 0, 0, 1, d, b);
      n_chk++;
      if (score_right !== 1 || score_left !== 0 || wall_hit !== 0 || dir_x_out !== 1 ||
          pix_x !== 11'd400 || pix_y !== 11'd300 || obs() !== expv()) begin
         n_fail++; $display("FAIL score_right: got %h want %h", obs(), expv());
      end
      do_load(2, 0);
      do_step(48, 1, 32, 1, d, b);
      n_chk++;
      if (score_left !== 1 || wall_hit !== 0 || obs() !== expv()) begin
         n_fail++; $display("FAIL score_left: got %h want %h", obs(), expv());
      end
   endtask

   task automatic test_random();
      logic [3:0] d, b;
      int vx, vy;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) do_load($urandom_range(0, 799), $urandom_range(0, 599));
         vx = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 32767) : $urandom_range(0, 16*25);
         vy = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 32767) : $urandom_range(0, 16*25);
         do_step(vx, 1'($urandom_range(0, 1)), vy, 1'($urandom_range(0, 1)), d, b);
         n_chk++;
         if (d !== 4'b1000 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL random[%0d]: got %h done=%b want %h vx=%0d vy=%0d", i, obs(), d, expv(), vx, vy);
         end
      end
   endtask

   task automatic test_back_to_back();
      int ndone;
      ndone = 0;
      @(negedge clk);
      step_req = 1; vx_mag = 15'd16; vx_dir = 0; vy_mag = 15'd16; vy_dir = 0;
      @(posedge clk);
      #1 step_req = 0;
      model_step(16, 0, 16, 0);
      @(negedge clk);
      load_req = 1; load_x = 11'd10; load_y = 11'd10;
      step_req = 1; vx_mag = 15'd800; vy_mag = 15'd800;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 ndone += int'(done);
      end
      load_req = 0; step_req = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1 ndone += int'(done);
      end
      n_chk++;
      if (ndone != 1 || obs() !== expv()) begin
         n_fail++; $display("FAIL ignore_busy: dones=%0d got %h want 1 %h", ndone, obs(), expv());
      end
   endtask

   task automatic test_reset_mid();
      int ndone;
      ndone = 0;
      do_load(50, 60);
      @(negedge clk);
      step_req = 1; vx_mag = 15'd32; vy_mag = 15'd32;
      @(posedge clk);
      #1 step_req = 0;
      #2 rst_n = 1;
      @(negedge clk) rst_n = 0;
      mx = 400*16; my = 300*16; mdx = 0; mdy = 0; mwall = 0; msl = 0; msr = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1 ndone += int'(done | busy);
      end
      n_chk++;
      if (ndone != 0 || obs() !== expv()) begin
         n_fail++; $display("FAIL reset_mid: done/busy=%0d got %h want 0 %h", ndone, obs(), expv());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_walls();
      test_score();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
